neurosync_input_conditioner: RTL and testbench
==============================================

// Module: neurosync_input_conditioner
// PURPOSE
//  Front-end for the NeuroSync controller. Takes the raw push-button inputs and
//  produces clean, single-cycle press pulses and stable levels for the controller's
//  dual datapath and control unit. Per channel: 2-FF synchronizer, polarity
//  correction, counter-based debounce, and rising-edge pulse generation.
//  Bit map: [0]jogar [1]confirma [2]reset_btn [3]direita [4]esquerda [8:5]botoes[3:0].
// PARAMETERS
//  N_ENTRADAS       9          number of button channels
//  DEBOUNCE_CICLOS  50000      consecutive stable cycles required (1 ms @ 50 MHz); >=2
//  ATIVO_BAIXO      9'h1E0     per-bit mask; 1 = raw input is active-low (inverted)
// PORTS
//  clock      in   1           system clock, all logic on rising edge
//  reset      in   1           asynchronous, active-low; clears all state
//  entradas   in   N_ENTRADAS  raw asynchronous button inputs
//  nivel      out  N_ENTRADAS  debounced level, 1 = pressed
//  pulso      out  N_ENTRADAS  1-cycle strobe on debounced press (0->1 of nivel)
//  solto      out  N_ENTRADAS  1-cycle strobe on debounced release (1->0 of nivel)
//  qualquer   out  1           OR of pulso (any new press this cycle)
// BEHAVIOUR
//  - Reset (reset=0, async): sync FFs, counters, nivel, pulso, solto, qualquer all 0.
//    Release is synchronous to clock; no output changes on the release edge itself.
//  - Per channel: r = entradas[i] ^ ATIVO_BAIXO[i]; s = r after two flops (s2 <- s1 <- r).
//  - Per-channel FSM, 4 states:
//    EST0 (nivel=0): s=1 -> CONT1, cnt<=1; else stay, cnt<=0.
//    CONT1: s=0 -> EST0, cnt<=0 (glitch rejected); s=1 & cnt<DEBOUNCE_CICLOS-1
//           -> cnt<=cnt+1; s=1 & cnt==DEBOUNCE_CICLOS-1 -> EST1, nivel<=1, pulso<=1.
//    EST1 (nivel=1): s=0 -> CONT0, cnt<=1; else stay.
//    CONT0: symmetric; completion -> EST0, nivel<=0, solto<=1.
//  - Counter width $clog2(DEBOUNCE_CICLOS); never wraps, saturates by FSM exit.
//  - Latency: raw change to nivel/pulso = 2 + DEBOUNCE_CICLOS clock edges, given
//    input stable throughout. pulso/solto are registered, high exactly one cycle,
//    coincident with the nivel transition cycle. qualquer is combinational OR of pulso.
//  - Any bounce shorter than DEBOUNCE_CICLOS cycles produces no output change.
//  - Channels are independent: simultaneous presses on several channels give
//    simultaneous pulses in the same cycle; no arbitration or priority.
//  - Button held through reset: after release it is treated as a new press;
//    pulso fires 2 + DEBOUNCE_CICLOS cycles after reset deasserts.
//  - Reset mid-count: count discarded; no pulso/solto issued for the aborted edge.
//  - Held button: exactly one pulso, no repeat; solto only after stable release.
//  - Channel [2] (reset_btn) is conditioned like the others; it does not reset this block.
// TESTING (bench uses DEBOUNCE_CICLOS=4, ATIVO_BAIXO=9'h1E0)
//  1. jogar 0->1 held 20 cycles -> nivel[0]=1 and pulso[0]=1 at edge 6 after change,
//     pulso[0] low next cycle, qualquer mirrors it; no further pulses while held.
//  2. confirma bounce 1,0,1,0 (one cycle each) then stable 1 -> no output during
//     bounce; single pulso[1] 6 cycles after final rise.
//  3. botoes[0] (active-low) raw 1->0 -> pulso[5] after 6 cycles; raw back to 1
//     for 10 cycles -> solto[5] once, nivel[5]=0.
//  4. direita and esquerda rise on the same edge -> pulso[4:3]=2'b11 in the same
//     cycle, qualquer=1 for that cycle only.
//  5. jogar held, reset pulsed low for 3 cycles mid-count (cnt=2) -> outputs 0
//     during reset; pulso[0] 6 cycles after reset release; no earlier pulse.
//  6. All inputs idle after reset (active-low bits raw=1) -> nivel=0, pulso=0,
//     solto=0 for 100 cycles.

Source files
------------

// File: rtl/neurosync_input_conditioner.sv
// NeuroSync push-button front end.
// Per channel: 2-FF sync, polarity fix, debounce FSM, press/release strobes.
module neurosync_input_conditioner #(
  parameter int N_ENTRADAS      = 9,
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter logic [N_ENTRADAS-1:0] ATIVO_BAIXO = 9'h1E0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_ENTRADAS-1:0] entradas,
  output logic [N_ENTRADAS-1:0] nivel,
  output logic [N_ENTRADAS-1:0] pulso,
  output logic [N_ENTRADAS-1:0] solto,
  output logic                  qualquer
);

  localparam int CW =
    (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    EST0,
    CONT1,
    EST1,
    CONT0
  } estado_t;

  logic [N_ENTRADAS-1:0] r;
  logic [N_ENTRADAS-1:0] s1;
  logic [N_ENTRADAS-1:0] s2;
  estado_t               st  [N_ENTRADAS];
  logic [CW-1:0]         cnt [N_ENTRADAS];

  assign r = entradas ^ ATIVO_BAIXO;

  // Two-flop synchronizer on the polarity-corrected inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= r;
      s2 <= s1;
    end
  end

  // Per-channel debounce FSM; strobes default low and fire for one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nivel <= '0;
      pulso <= '0;
      solto <= '0;
      for (int i = 0; i < N_ENTRADAS; i++) begin
        st[i]  <= EST0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ENTRADAS; i++) begin
        pulso[i] <= 1'b0;
        solto[i] <= 1'b0;
        unique case (st[i])
          EST0: begin
            if (s2[i]) begin
              st[i]  <= CONT1;
              cnt[i] <= CNT_ONE;
            end else begin
              cnt[i] <= '0;
            end
          end
          CONT1: begin
            if (!s2[i]) begin
              st[i]  <= EST0;
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
              st[i]    <= EST1;
              cnt[i]   <= '0;
              nivel[i] <= 1'b1;
              pulso[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          EST1: begin
            if (!s2[i]) begin
              st[i]  <= CONT0;
              cnt[i] <= CNT_ONE;
            end else begin
              cnt[i] <= '0;
            end
          end
          CONT0: begin
            if (s2[i]) begin
              st[i]  <= EST1;
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
              st[i]    <= EST0;
              cnt[i]   <= '0;
              nivel[i] <= 1'b0;
              solto[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          default: begin
            st[i]  <= EST0;
            cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  assign qualquer = |pulso;

endmodule

// File: tb/tb_neurosync_input_conditioner.sv
// Bench for neurosync_input_conditioner.
// Vector table, directed corner sequences and random stimulus vs a model.
module tb_neurosync_input_conditioner;

  localparam int N = 9;
  localparam int D = 4;
  localparam logic [8:0] AB = 9'h1E0;
  localparam logic [8:0] IDLE = 9'h1E0;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] entradas = IDLE;
  logic [8:0] nivel;
  logic [8:0] pulso;
  logic [8:0] solto;
  logic       qualquer;

  neurosync_input_conditioner #(
    .N_ENTRADAS(N),
    .DEBOUNCE_CICLOS(D),
    .ATIVO_BAIXO(AB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .entradas(entradas),
    .nivel(nivel),
    .pulso(pulso),
    .solto(solto),
    .qualquer(qualquer)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference: pressed-sense delayed two samples; the level flips once
  // the delayed sample has disagreed with it for D samples in a row.
  logic [8:0] p1 = '0;
  logic [8:0] p2 = '0;
  logic [8:0] m_lvl = '0;
  logic [8:0] m_pul = '0;
  logic [8:0] m_sol = '0;
  int         run [N];

  typedef struct {
    logic       rn;
    logic [8:0] e;
    logic [8:0] lv;
    logic [8:0] pu;
    logic [8:0] so;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [8:0] s;
    if (!reset) begin
      p1 = '0;
      p2 = '0;
      m_lvl = '0;
      m_pul = '0;
      m_sol = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      s = p2;
      p2 = p1;
      p1 = entradas ^ AB;
      m_pul = '0;
      m_sol = '0;
      for (int i = 0; i < N; i++) begin
        if (s[i] != m_lvl[i]) run[i]++;
        else run[i] = 0;
        if (run[i] == D) begin
          m_lvl[i] = s[i];
          run[i] = 0;
          if (s[i]) m_pul[i] = 1'b1;
          else m_sol[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic rn, input logic [8:0] e);
    @(negedge clock);
    reset = rn;
    entradas = e;
    @(posedge clock);
    model_edge();
    #1;
    chk("m_nivel", 32'(nivel), 32'(m_lvl));
    chk("m_pulso", 32'(pulso), 32'(m_pul));
    chk("m_solto", 32'(solto), 32'(m_sol));
    chk("m_qualquer", 32'(qualquer), 32'(|m_pul));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, IDLE);
  endtask

  int         first;
  int         cnt;
  logic [8:0] acc;
  logic [8:0] e;
  logic       rn;

  initial begin
    for (int i = 0; i < N; i++) run[i] = 0;

    // Vector table: reset, jogar press held 20, then release.
    for (int i = 0; i < 3; i++)
      tv.push_back('{1'b0, IDLE, 9'h0, 9'h0, 9'h0});
    tv.push_back('{1'b1, IDLE, 9'h0, 9'h0, 9'h0});
    for (int i = 0; i < 20; i++)
      tv.push_back('{1'b1, IDLE | 9'h001,
                     (i >= 5) ? 9'h001 : 9'h000,
                     (i == 5) ? 9'h001 : 9'h000, 9'h000});
    for (int i = 0; i < 10; i++)
      tv.push_back('{1'b1, IDLE,
                     (i < 5) ? 9'h001 : 9'h000, 9'h000,
                     (i == 5) ? 9'h001 : 9'h000});

    #1;
    chk("reset_nivel", 32'(nivel), 32'h0);
    chk("reset_pulso", 32'(pulso), 32'h0);
    chk("reset_solto", 32'(solto), 32'h0);

    foreach (tv[k]) begin
      step(tv[k].rn, tv[k].e);
      chk("tv_nivel", 32'(nivel), 32'(tv[k].lv));
      chk("tv_pulso", 32'(pulso), 32'(tv[k].pu));
      chk("tv_solto", 32'(solto), 32'(tv[k].so));
      chk("tv_qualquer", 32'(qualquer), 32'(|tv[k].pu));
    end

    // Bounce on confirma, then stable press.
    cnt = 0;
    step(1'b1, IDLE | 9'h002);
    cnt += int'(pulso[1]);
    step(1'b1, IDLE);
    cnt += int'(pulso[1]);
    step(1'b1, IDLE | 9'h002);
    cnt += int'(pulso[1]);
    step(1'b1, IDLE);
    cnt += int'(pulso[1]);
    chk("bounce_no_pulse", 32'(cnt), 32'd0);
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, IDLE | 9'h002);
      if (pulso[1]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk("bounce_pulse_at", 32'(first), 32'd5);
    chk("bounce_pulse_cnt", 32'(cnt), 32'd1);
    idle(10);

    // Active-low botoes[0]: raw low is a press.
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, IDLE & ~9'h020);
      if (pulso[5] && first < 0) first = i;
    end
    chk("al_pulse_at", 32'(first), 32'd5);
    chk("al_nivel", 32'(nivel[5]), 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, IDLE);
      cnt += int'(solto[5]);
    end
    chk("al_solto_cnt", 32'(cnt), 32'd1);
    chk("al_nivel_rel", 32'(nivel[5]), 32'd0);

    // direita and esquerda together.
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, IDLE | 9'h018);
      cnt += int'(qualquer);
      if (i == 5) begin
        chk("dual_pulso", 32'(pulso[4:3]), 32'd3);
        chk("dual_qualquer", 32'(qualquer), 32'd1);
      end
    end
    chk("dual_q_cnt", 32'(cnt), 32'd1);
    idle(10);

    // Reset mid-count with jogar held.
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, IDLE | 9'h001);
      cnt += int'(pulso[0]);
    end
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, IDLE | 9'h001);
      acc |= nivel | pulso | solto;
    end
    chk("rst_mid_out", 32'(acc), 32'h0);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, IDLE | 9'h001);
      if (pulso[0]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk("rst_mid_at", 32'(first), 32'd5);
    chk("rst_mid_cnt", 32'(cnt), 32'd1);
    idle(10);

    // Idle after reset for 100 cycles.
    step(1'b0, IDLE);
    acc = '0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, IDLE);
      acc |= nivel | pulso | solto;
    end
    chk("idle_quiet", 32'(acc), 32'h0);

    // Random slowly-toggling inputs with occasional reset.
    e = IDLE;
    for (int k = 0; k < 2000; k++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) e[b] = ~e[b];
      rn = ($urandom_range(0, 299) != 0);
      step(rn, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
